ad9958_spi_serializer: RTL and testbench
========================================

Name: ad9958_spi_serializer

Overview:
- Downstream of the AD9958 sequencing core. It consumes that core's trigger, packs_to_send and data_input, and drives the AD9958 serial port in 4-bit I/O mode (SCLK, CS_N, SDIO_0..3).
- It reports busy back to the core so the core can pace its register writes.
- It holds CS low between back-to-back transfers. This lets an instruction byte and the data bytes that follow it form one AD9958 communication cycle.

Parameters:
- SCLK_DIV, 2: system clocks per SCLK half-period. Legal range 1..255.
- CS_HOLD_CYCLES, 16: idle system clocks, after a transfer ends, before CS_N is released. Legal range 1..1023.

Ports:
- clock  input  1  system clock. All logic is on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- trigger  input  1  one-cycle transfer request from the core.
- packs_to_send  input  5  number of 4-bit nibbles to send.
- data_input  input  64  payload. Right-aligned: the transmitted bits are data_input[4*packs_to_send-1:0].
- busy  output  1  high while a transfer is in progress.
- sclk  output  1  serial clock to the DDS. Idles low.
- cs_n  output  1  chip select to the DDS, active low.
- sdio  output  4  nibble lanes. sdio[3] carries the nibble MSB.

Behaviour:
- Reset (asynchronous, reset_n=0): busy=0, sclk=0, cs_n=1, sdio=0, all counters=0, state=IDLE. Reset mid-transfer aborts immediately. No partial-frame recovery.
- States: IDLE, SETUP, SCLK_HI, SCLK_LO, HOLD.
- IDLE: cs_n=1. A rising edge with trigger=1 and packs_to_send!=0 does the following on that edge:
  - latch shift register = data_input << (64 - 4*P), so the payload is MSB-aligned;
  - remaining = P;
  - sdio = shift[63:60];
  - cs_n=0, busy=1;
  - go to SETUP.
- packs_to_send > 16 is clamped to P=16.
- packs_to_send=0 is ignored: busy stays 0 and the state does not change.
- busy must be 1 from the edge that samples trigger. The core tests busy|trigger two cycles after it raises trigger, so a later busy would be missed.
- SETUP: sclk=0 for SCLK_DIV cycles, then sclk→1 and go to SCLK_HI. This gives the DDS setup time.
- SCLK_HI: hold sclk=1 for SCLK_DIV cycles, then decrement remaining.
  - If remaining becomes 0: sclk→0, busy→0, go to HOLD. cs_n stays 0.
  - Otherwise: sclk→0, shift left by 4, sdio = next nibble on the same edge, go to SCLK_LO.
- SCLK_LO: hold sclk=0 for SCLK_DIV cycles, then sclk→1 and go to SCLK_HI.
- Data timing: sdio changes only on SCLK falling transitions, or at start of a transfer. The DDS samples on SCLK rising.
- Transfer duration: busy is high for exactly 2*P*SCLK_DIV clock cycles, with P rising SCLK edges.
- HOLD: cs_n=0, sclk=0, busy=0, and the idle counter increments each cycle.
  - trigger=1 with a nonzero pack count: start a new transfer exactly as from IDLE, with cs_n unchanged at 0, and reset the idle counter.
  - Idle counter reaches CS_HOLD_CYCLES: cs_n→1, sdio→0, go to IDLE.
  - Simultaneous trigger and timeout: trigger wins and cs_n stays 0.
- trigger while busy=1 (SETUP, SCLK_HI, SCLK_LO) is ignored. data_input and packs_to_send are not re-sampled.
- Width rules:
  - the shift amount 64-4*P is computed in 7 bits;
  - remaining is 5 bits;
  - the half-period counter is 8 bits;
  - the idle counter is 10 bits and saturates.

Test Plan:
- Instruction byte, SCLK_DIV=2: trigger with packs=2, data=0x04 → busy high 8 cycles; cs_n falls on the trigger edge; sdio sequence 0x0 then 0x4; 2 SCLK rising edges; cs_n still 0 afterwards.
- FTW write: packs=8, data=0x12345678 → sdio 1,2,3,4,5,6,7,8 on successive rising edges; busy high 32 cycles; no sdio change while sclk=1.
- Chained frame: instruction (packs=2, 0x04), then trigger 3 cycles after busy falls with packs=8, 0xDEADBEEF → cs_n stays 0 across both; 10 total SCLK edges; cs_n rises 16 cycles after the second busy falls.
- Edge inputs: packs=0 → busy stays 0 and cs_n stays 1; packs=20, data=0xFEDCBA9876543210 → clamped to 16 nibbles, F..0 sent; busy high 64 cycles.
- Ignored trigger: trigger pulse during busy with a different payload → original transfer completes unchanged.
- Reset mid-transfer: assert reset_n=0 after the 3rd SCLK rise → busy=0, cs_n=1, sclk=0, sdio=0 immediately, without waiting for a clock edge; a fresh trigger after release starts a clean transfer.

Source files
------------

// File: rtl/ad9958_spi_serializer_if.sv
// Core-to-serializer handshake and the AD9958 4-bit serial pins, bundled as one interface.
// The serializer is the slave; the sequencing core / DDS side is the master.
interface ad9958_spi_serializer_if;
  logic        trigger;
  logic [4:0]  packs_to_send;
  logic [63:0] data_input;
  logic        busy;
  logic        sclk;
  logic        cs_n;
  logic [3:0]  sdio;

  modport master (
    output trigger, packs_to_send, data_input,
    input  busy, sclk, cs_n, sdio
  );

  modport slave (
    input  trigger, packs_to_send, data_input,
    output busy, sclk, cs_n, sdio
  );
endinterface

// File: rtl/ad9958_spi_serializer.sv
// AD9958 4-bit-mode serial port driver: shifts up to 16 nibbles MSB-first and
// keeps CS_N low for CS_HOLD_CYCLES after a transfer so follow-up bytes chain.
module ad9958_spi_serializer #(
  parameter int SCLK_DIV       = 2,
  parameter int CS_HOLD_CYCLES = 16
) (
  input  logic                         clock,
  input  logic                         reset_n,
  ad9958_spi_serializer_if.slave       bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    SCLK_HI = 3'd2,
    SCLK_LO = 3'd3,
    HOLD    = 3'd4
  } state_t;

  state_t      state_q;
  logic [63:0] shift_q;
  logic [4:0]  remaining_q;
  logic [7:0]  cnt_q;
  logic [9:0]  idle_q;
  logic        busy_q;
  logic        sclk_q;
  logic        cs_n_q;
  logic [3:0]  sdio_q;

  logic [4:0]  packs_d;
  logic [6:0]  shamt_d;
  logic [63:0] aligned_d;
  logic        start_d;
  logic        half_done_d;
  logic [9:0]  idle_d;

  // Payload is right-aligned on the input; move it to the top so nibbles leave MSB-first.
  assign packs_d     = (bus.packs_to_send > 5'd16) ? 5'd16 : bus.packs_to_send;
  assign shamt_d     = 7'd64 - {packs_d, 2'b00};
  assign aligned_d   = bus.data_input << shamt_d;
  assign start_d     = bus.trigger && (packs_d != 5'd0);
  assign half_done_d = (cnt_q == 8'(SCLK_DIV - 1));
  assign idle_d      = (idle_q == 10'h3FF) ? idle_q : idle_q + 10'd1;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      remaining_q <= '0;
      cnt_q       <= '0;
      idle_q      <= '0;
      busy_q      <= 1'b0;
      sclk_q      <= 1'b0;
      cs_n_q      <= 1'b1;
      sdio_q      <= '0;
    end else begin
      case (state_q)
        IDLE, HOLD: begin
          if (start_d) begin
            shift_q     <= aligned_d;
            remaining_q <= packs_d;
            sdio_q      <= aligned_d[63:60];
            cs_n_q      <= 1'b0;
            busy_q      <= 1'b1;
            sclk_q      <= 1'b0;
            cnt_q       <= '0;
            idle_q      <= '0;
            state_q     <= SETUP;
          end else if (state_q == HOLD) begin
            // A trigger on the timeout edge is handled above, so CS_N stays low then.
            idle_q <= idle_d;
            if (idle_d == 10'(CS_HOLD_CYCLES)) begin
              cs_n_q  <= 1'b1;
              sdio_q  <= '0;
              state_q <= IDLE;
            end
          end
        end

        SETUP, SCLK_LO: begin
          if (half_done_d) begin
            cnt_q   <= '0;
            sclk_q  <= 1'b1;
            state_q <= SCLK_HI;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end

        SCLK_HI: begin
          if (half_done_d) begin
            cnt_q  <= '0;
            sclk_q <= 1'b0;
            if (remaining_q == 5'd1) begin
              remaining_q <= '0;
              busy_q      <= 1'b0;
              idle_q      <= '0;
              state_q     <= HOLD;
            end else begin
              // Next nibble goes out on the falling SCLK so it is stable at the next rise.
              remaining_q <= remaining_q - 5'd1;
              shift_q     <= shift_q << 4;
              sdio_q      <= shift_q[59:56];
              state_q     <= SCLK_LO;
            end
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.sclk = sclk_q;
  assign bus.cs_n = cs_n_q;
  assign bus.sdio = sdio_q;

endmodule

// File: tb/tb_ad9958_spi_serializer.sv
// Randomized bench for ad9958_spi_serializer: observes the serial pins and compares
// them with nibble lists and timings computed from the transfer rules.
module tb_ad9958_spi_serializer;
  localparam int SCLK_DIV = 2;
  localparam int CS_HOLD  = 16;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  ad9958_spi_serializer_if bus ();

  ad9958_spi_serializer #(
    .SCLK_DIV      (SCLK_DIV),
    .CS_HOLD_CYCLES(CS_HOLD)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int clamp_packs(input int packs);
    return (packs > 16) ? 16 : packs;
  endfunction

  // Nibble i (0 = first on the wire) of a P-nibble right-aligned payload.
  function automatic logic [3:0] model_nibble(input logic [63:0] d, input int p, input int i);
    logic [63:0] t;
    t = d >> (4 * (p - 1 - i));
    return t[3:0];
  endfunction

  task automatic do_xfer(input string tag, input int packs, input logic [63:0] data,
                         input logic cs_before, input int inject_at);
    int p;
    int n;
    int guard;
    int glitches;
    logic [3:0] got[$];
    logic prev_sclk;
    logic [3:0] prev_sdio;
    p = clamp_packs(packs);
    @(negedge clock);
    check_eq({tag, "_cs_pre"}, 64'(bus.cs_n), 64'(cs_before));
    bus.trigger       = 1'b1;
    bus.packs_to_send = 5'(packs);
    bus.data_input    = data;
    @(posedge clock); #1;
    bus.trigger       = 1'b0;
    bus.packs_to_send = 5'($urandom);
    bus.data_input    = {$urandom, $urandom};
    check_eq({tag, "_busy_start"}, 64'(bus.busy), 64'd1);
    check_eq({tag, "_cs_start"}, 64'(bus.cs_n), 64'd0);
    n = 0; guard = 0; glitches = 0;
    prev_sclk = 1'b0; prev_sdio = bus.sdio;
    while (bus.busy && guard < 2000) begin
      n++; guard++;
      if (bus.sclk && !prev_sclk) got.push_back(bus.sdio);
      if (bus.sclk && prev_sclk && bus.sdio != prev_sdio) glitches++;
      prev_sclk = bus.sclk;
      prev_sdio = bus.sdio;
      if (n == inject_at) begin
        bus.trigger       = 1'b1;
        bus.packs_to_send = 5'd3;
        bus.data_input    = ~data;
      end else begin
        bus.trigger = 1'b0;
      end
      @(posedge clock); #1;
    end
    bus.trigger = 1'b0;
    check_eq({tag, "_busy_cycles"}, 64'(n), 64'(2 * p * SCLK_DIV));
    check_eq({tag, "_nibble_count"}, 64'(got.size()), 64'(p));
    for (int i = 0; i < got.size() && i < p; i++)
      check_eq($sformatf("%s_nib%0d", tag, i), 64'(got[i]), 64'(model_nibble(data, p, i)));
    check_eq({tag, "_sdio_stable_hi"}, 64'(glitches), 64'd0);
    check_eq({tag, "_cs_after"}, 64'(bus.cs_n), 64'd0);
    check_eq({tag, "_sclk_after"}, 64'(bus.sclk), 64'd0);
  endtask

  task automatic wait_release(input string tag);
    int n;
    n = 0;
    while (bus.cs_n == 1'b0 && n < 200) begin
      @(posedge clock); #1;
      n++;
      if (bus.sclk || bus.busy) check_eq({tag, "_hold_quiet"}, {62'd0, bus.sclk, bus.busy}, 64'd0);
    end
    check_eq({tag, "_hold_cycles"}, 64'(n), 64'(CS_HOLD));
    check_eq({tag, "_sdio_idle"}, 64'(bus.sdio), 64'd0);
  endtask

  task automatic gap(input string tag, input int cycles);
    repeat (cycles) begin
      @(posedge clock); #1;
      check_eq({tag, "_gap_cs"}, 64'(bus.cs_n), 64'd0);
    end
  endtask

  initial begin
    int rises;
    int guard;
    logic prev_sclk;
    logic cs_idle;
    bus.trigger       = 1'b0;
    bus.packs_to_send = '0;
    bus.data_input    = '0;
    repeat (2) @(negedge clock);
    check_eq("reset_busy", 64'(bus.busy), 64'd0);
    check_eq("reset_cs", 64'(bus.cs_n), 64'd1);
    check_eq("reset_sclk", 64'(bus.sclk), 64'd0);
    check_eq("reset_sdio", 64'(bus.sdio), 64'd0);
    reset_n = 1'b1;

    do_xfer("instr", 2, 64'h04, 1'b1, -1);
    wait_release("instr");
    do_xfer("ftw", 8, 64'h12345678, 1'b1, -1);
    wait_release("ftw");

    do_xfer("chain_a", 2, 64'h04, 1'b1, -1);
    gap("chain", 2);
    do_xfer("chain_b", 8, 64'hDEADBEEF, 1'b0, -1);
    wait_release("chain");

    @(negedge clock);
    bus.trigger = 1'b1; bus.packs_to_send = 5'd0; bus.data_input = 64'hFFFF;
    @(posedge clock); #1;
    bus.trigger = 1'b0;
    repeat (4) begin
      check_eq("zero_busy", 64'(bus.busy), 64'd0);
      check_eq("zero_cs", 64'(bus.cs_n), 64'd1);
      @(posedge clock); #1;
    end

    do_xfer("clamp", 20, 64'hFEDCBA9876543210, 1'b1, -1);
    wait_release("clamp");

    do_xfer("ignored", 8, 64'hCAFEF00D, 1'b1, 5);
    wait_release("ignored");

    do_xfer("race_a", 4, 64'hA5C3, 1'b1, -1);
    gap("race", 15);
    do_xfer("race_b", 3, 64'h7E1, 1'b0, -1);
    wait_release("race");

    // Reset in the middle of a frame, away from any clock edge.
    @(negedge clock);
    bus.trigger = 1'b1; bus.packs_to_send = 5'd8; bus.data_input = {$urandom, $urandom};
    @(posedge clock); #1;
    bus.trigger = 1'b0;
    rises = 0; guard = 0; prev_sclk = 1'b0;
    while (rises < 3 && guard < 500) begin
      if (bus.sclk && !prev_sclk) rises++;
      prev_sclk = bus.sclk;
      guard++;
      if (rises < 3) begin
        @(posedge clock); #1;
      end
    end
    check_eq("rst_mid_rises", 64'(rises), 64'd3);
    #2 reset_n = 1'b0;
    #1;
    check_eq("rst_mid_busy", 64'(bus.busy), 64'd0);
    check_eq("rst_mid_cs", 64'(bus.cs_n), 64'd1);
    check_eq("rst_mid_sclk", 64'(bus.sclk), 64'd0);
    check_eq("rst_mid_sdio", 64'(bus.sdio), 64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    do_xfer("post_rst", 5, 64'h13579, 1'b1, -1);
    wait_release("post_rst");

    cs_idle = 1'b1;
    for (int k = 0; k < 25; k++) begin
      int packs;
      int mode;
      logic [63:0] data;
      packs = int'($urandom_range(1, 20));
      data  = {$urandom, $urandom};
      do_xfer($sformatf("rnd%0d", k), packs, data, cs_idle, -1);
      mode = int'($urandom_range(0, 2));
      if (mode == 0 || k == 24) begin
        wait_release($sformatf("rnd%0d", k));
        cs_idle = 1'b1;
      end else begin
        gap($sformatf("rnd%0d", k), (mode == 1) ? int'($urandom_range(0, 14)) : 15);
        cs_idle = 1'b0;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
